// File: rtl/branch_pc_unit.sv
// Fetch PC register with D-stage branch/jump resolution (MIPS delayed-branch style),
// link address, sticky misaligned-target flag and taken/not-taken event counters.
module branch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        d_valid,
  input  logic [2:0]  br_op,
  input  logic        equ,
  input  logic        gez,
  input  logic [31:0] pc_d,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] pc_f,
  output logic [31:0] pc8_d,
  output logic        taken_d,
  output logic        addr_err,
  output logic [31:0] taken_cnt,
  output logic [31:0] ntaken_cnt
);

  typedef enum logic [2:0] {
    OpNone = 3'd0,
    OpBeq  = 3'd1,
    OpBne  = 3'd2,
    OpBgez = 3'd3,
    OpBltz = 3'd4,
    OpJump = 3'd5,
    OpJr   = 3'd6,
    OpRsvd = 3'd7
  } br_op_e;

  br_op_e      op;
  logic        cond;
  logic        is_cond_br;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] target;
  logic        target_misaligned;
  logic        resolve;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] ntaken_cnt_q, ntaken_cnt_d;
  logic        addr_err_q, addr_err_d;

  assign op = br_op_e'(br_op);

  // Branch offset is relative to the delay-slot PC.
  assign br_target = pc_d + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target  = {pc_d[31:28], instr_index, 2'b00};

  always_comb begin
    cond       = 1'b0;
    is_cond_br = 1'b0;
    target     = br_target;
    unique case (op)
      OpBeq: begin
        cond       = equ;
        is_cond_br = 1'b1;
      end
      OpBne: begin
        cond       = ~equ;
        is_cond_br = 1'b1;
      end
      OpBgez: begin
        cond       = gez;
        is_cond_br = 1'b1;
      end
      OpBltz: begin
        cond       = ~gez;
        is_cond_br = 1'b1;
      end
      OpJump: begin
        cond   = 1'b1;
        target = j_target;
      end
      OpJr: begin
        cond   = 1'b1;
        target = rs_val;
      end
      OpNone, OpRsvd: begin
        cond = 1'b0;
      end
      default: begin
        cond = 1'b0;
      end
    endcase
  end

  assign taken_d           = d_valid & cond;
  assign pc8_d             = pc_d + 32'd8;
  assign target_misaligned = |target[1:0];
  // A stalled branch is only re-evaluated; it resolves on the first unstalled cycle.
  assign resolve           = ~stall;

  always_comb begin
    pc_f_d       = pc_f_q;
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    addr_err_d   = addr_err_q;
    if (resolve) begin
      pc_f_d = taken_d ? target : pc_f_q + 32'd4;
      if (taken_d) begin
        taken_cnt_d = taken_cnt_q + 32'd1;
        if (target_misaligned) begin
          addr_err_d = 1'b1;
        end
      end else if (d_valid && is_cond_br) begin
        ntaken_cnt_d = ntaken_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f_q       <= RESET_PC;
      taken_cnt_q  <= 32'd0;
      ntaken_cnt_q <= 32'd0;
      addr_err_q   <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign pc_f       = pc_f_q;
  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed vector table, stall/misalign/wrap/reset
// sequences, and randomized cycles against a behavioural model.
module tb_branch_pc_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        d_valid;
  logic [2:0]  br_op;
  logic        equ;
  logic        gez;
  logic [31:0] pc_d;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic [31:0] pc_f;
  logic [31:0] pc8_d;
  logic        taken_d;
  logic        addr_err;
  logic [31:0] taken_cnt;
  logic [31:0] ntaken_cnt;

  branch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .d_valid    (d_valid),
    .br_op      (br_op),
    .equ        (equ),
    .gez        (gez),
    .pc_d       (pc_d),
    .imm16      (imm16),
    .instr_index(instr_index),
    .rs_val     (rs_val),
    .pc_f       (pc_f),
    .pc8_d      (pc8_d),
    .taken_d    (taken_d),
    .addr_err   (addr_err),
    .taken_cnt  (taken_cnt),
    .ntaken_cnt (ntaken_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_tk;
  logic [31:0] m_nt;
  logic        m_err;

  typedef struct {
    logic [2:0]  op;
    logic        v;
    logic        e;
    logic        g;
    logic [31:0] pcd;
    logic [15:0] imm;
    logic [25:0] idx;
    logic [31:0] rs;
    logic        exp_tk;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic m_taken(input logic [2:0] op, input logic v, input logic e,
                                   input logic g);
    logic c;
    case (op)
      3'd1:    c = e;
      3'd2:    c = !e;
      3'd3:    c = g;
      3'd4:    c = !g;
      3'd5:    c = 1'b1;
      3'd6:    c = 1'b1;
      default: c = 1'b0;
    endcase
    return v && c;
  endfunction

  function automatic logic [31:0] m_target(input logic [2:0] op, input logic [31:0] pcd,
                                           input logic [15:0] imm, input logic [25:0] idx,
                                           input logic [31:0] rs);
    int off;
    if (op == 3'd5) return (pcd & 32'hF000_0000) | (32'(idx) << 2);
    if (op == 3'd6) return rs;
    off = int'($signed(imm)) * 4;
    return pcd + 32'd4 + 32'(off);
  endfunction

  task automatic m_reset();
    m_pc  = RST_PC;
    m_tk  = 0;
    m_nt  = 0;
    m_err = 0;
  endtask

  task automatic drive(input logic s, input logic v, input logic [2:0] op, input logic e,
                       input logic g, input logic [31:0] pcd, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs);
    stall = s; d_valid = v; br_op = op; equ = e; gez = g;
    pc_d = pcd; imm16 = imm; instr_index = idx; rs_val = rs;
  endtask

  // Called just after a rising edge: checks comb outputs, clocks once, checks state.
  task automatic step();
    logic        tk;
    logic [31:0] tgt;
    #2;
    tk  = m_taken(br_op, d_valid, equ, gez);
    tgt = m_target(br_op, pc_d, imm16, instr_index, rs_val);
    chk("taken_d", 32'(taken_d), 32'(tk));
    chk("pc8_d", pc8_d, pc_d + 32'd8);
    @(posedge clk);
    if (!stall) begin
      if (tk) m_tk = m_tk + 1;
      else if (d_valid && br_op >= 3'd1 && br_op <= 3'd4) m_nt = m_nt + 1;
      if (tk && (tgt % 4) != 0) m_err = 1'b1;
      m_pc = tk ? tgt : m_pc + 32'd4;
    end
    #1;
    chk("pc_f", pc_f, m_pc);
    chk("taken_cnt", taken_cnt, m_tk);
    chk("ntaken_cnt", ntaken_cnt, m_nt);
    chk("addr_err", 32'(addr_err), 32'(m_err));
  endtask

  initial begin
    logic [31:0] prev_pc, saved_pc, saved_tk, saved_nt;

    vecs.push_back('{3'd1, 1, 1, 0, 32'h0000_3004, 16'hFFFE, 26'h0, 32'h0, 1, 32'h0000_3000});
    vecs.push_back('{3'd1, 1, 0, 0, 32'h0000_3004, 16'hFFFE, 26'h0, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd2, 1, 0, 1, 32'h0000_3000, 16'h0004, 26'h0, 32'h0, 1, 32'h0000_3014});
    vecs.push_back('{3'd2, 1, 1, 1, 32'h0000_3000, 16'h0004, 26'h0, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd3, 1, 0, 1, 32'h0000_3100, 16'h0001, 26'h0, 32'h0, 1, 32'h0000_3108});
    vecs.push_back('{3'd4, 1, 0, 1, 32'h0000_3100, 16'h0001, 26'h0, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd3, 1, 1, 0, 32'h0000_3100, 16'h0010, 26'h0, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd4, 1, 1, 0, 32'h0000_3100, 16'h0010, 26'h0, 32'h0, 1, 32'h0000_3144});
    vecs.push_back('{3'd5, 1, 0, 0, 32'h0000_3008, 16'h0, 26'h0000C10, 32'h0, 1, 32'h0000_3040});
    vecs.push_back('{3'd5, 1, 0, 0, 32'hF000_0000, 16'h0, 26'h3FF_FFFF, 32'h0, 1, 32'hFFFF_FFFC});
    vecs.push_back('{3'd6, 1, 0, 0, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_4000, 1, 32'h0000_4000});
    vecs.push_back('{3'd0, 1, 1, 1, 32'h0000_3000, 16'h0004, 26'h0, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd7, 1, 1, 1, 32'h0000_3000, 16'h0004, 26'h0, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd5, 0, 1, 1, 32'h0000_3008, 16'h0, 26'h0000C10, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd1, 0, 1, 1, 32'h0000_3004, 16'hFFFE, 26'h0, 32'h0, 0, 32'h0});
    vecs.push_back('{3'd1, 1, 1, 0, 32'hFFFF_FFFC, 16'h0000, 26'h0, 32'h0, 1, 32'h0000_0000});

    // Reset and free-running fetch
    reset = 1'b1;
    drive(0, 0, 3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    m_reset();
    #3;
    chk("rst_pc_f", pc_f, RST_PC);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
    chk("rst_ntaken_cnt", ntaken_cnt, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    #9;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("pc_after_3", pc_f, 32'h0000_300C);

    // Directed vector table
    foreach (vecs[i]) begin
      drive(0, vecs[i].v, vecs[i].op, vecs[i].e, vecs[i].g, vecs[i].pcd, vecs[i].imm,
            vecs[i].idx, vecs[i].rs);
      prev_pc = pc_f;
      #1;
      chk($sformatf("vec%0d_taken", i), 32'(taken_d), 32'(vecs[i].exp_tk));
      step();
      chk($sformatf("vec%0d_pc", i), pc_f, vecs[i].exp_tk ? vecs[i].exp_tgt : prev_pc + 32'd4);
    end

    // Stalled taken beq with flipping equ, then a single redirect on release
    saved_pc = pc_f;
    saved_tk = taken_cnt;
    saved_nt = ntaken_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 3'd1, i[0], 0, 32'h0000_3004, 16'hFFFE, 26'h0, 32'h0);
      step();
    end
    chk("stall_pc", pc_f, saved_pc);
    chk("stall_tk", taken_cnt, saved_tk);
    chk("stall_nt", ntaken_cnt, saved_nt);
    drive(0, 1, 3'd1, 1, 0, 32'h0000_3004, 16'hFFFE, 26'h0, 32'h0);
    step();
    chk("stall_rel_pc", pc_f, 32'h0000_3000);
    chk("stall_rel_tk", taken_cnt, saved_tk + 32'd1);
    drive(0, 0, 3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    step();
    chk("stall_once_tk", taken_cnt, saved_tk + 32'd1);

    // Misaligned jr sets a sticky flag
    drive(0, 1, 3'd6, 0, 0, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3006);
    step();
    chk("jr_mis_pc", pc_f, 32'h0000_3006);
    chk("jr_mis_err", 32'(addr_err), 32'd1);
    drive(0, 1, 3'd5, 0, 0, 32'h0000_3008, 16'h0, 26'h0000C10, 32'h0);
    step();
    drive(0, 1, 3'd6, 0, 0, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_5000);
    step();
    chk("err_sticky", 32'(addr_err), 32'd1);

    // Taken counter wrap
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.taken_cnt_q;
    m_tk = 32'hFFFF_FFFF;
    drive(0, 1, 3'd5, 0, 0, 32'h0000_3008, 16'h0, 26'h0000C10, 32'h0);
    step();
    chk("tk_wrap", taken_cnt, 32'd0);

    // Randomized cycles against the model
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 5) == 0, ($urandom % 8) != 0, 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, 16'($urandom),
            26'($urandom), (($urandom % 6) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
      step();
    end

    // Asynchronous reset mid-operation discards a pending redirect
    drive(0, 1, 3'd5, 0, 0, 32'h0000_3008, 16'h0, 26'h0000C10, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_pc", pc_f, RST_PC);
    chk("mid_rst_tk", taken_cnt, 32'd0);
    chk("mid_rst_nt", ntaken_cnt, 32'd0);
    chk("mid_rst_err", 32'(addr_err), 32'd0);
    @(posedge clk);
    #1;
    chk("in_rst_pc", pc_f, RST_PC);
    reset = 1'b0;
    m_reset();
    drive(0, 1, 3'd0, 0, 0, 32'h0, 16'h0, 26'h0, 32'h0);
    step();
    chk("post_rst_pc", pc_f, RST_PC + 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
